stage_sequencer: RTL and testbench

Multi-cycle control FSM that sequences the core's fetch, decode, execute, memory and writeback steps. It drives instruction-memory and data-memory request handshakes, the instruction-latch, ALU and register-file write strobes, and owns the program counter. It replaces the free-running per-clock PC increment in `core`. Illegal instructions and memory timeouts end in a sticky trap state.

---
 rtl/stage_sequencer.sv | 161 ++++++++++++++++
 tb/tb_stage_sequencer.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/stage_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer that owns the PC and traps on illegal ops or memory timeouts.
// Optional retired-instruction counter is enabled by defining SEQ_INSTRET_EN.
module stage_sequencer #(
  parameter logic [31:0] RESET_PC    = 32'h0,
  parameter logic [31:0] PC_STEP     = 32'd1,
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  output logic        imem_req,
  input  logic        imem_ready,
  output logic        inst_latch_en,
  input  logic        illegal,
  input  logic        is_load,
  input  logic        is_store,
  input  logic        writes_rd,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        alu_en,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ready,
  output logic        rf_we,
  output logic        retire,
  output logic [31:0] pc,
  output logic        trap,
  output logic [1:0]  trap_cause,
  output logic [31:0] instret
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_TRAP   = 3'd5;

  localparam int unsigned CNT_W = (MEM_TIMEOUT > 32'd1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] TMO_LAST =
    CNT_W'((MEM_TIMEOUT > 32'd0) ? (MEM_TIMEOUT - 32'd1) : 32'd0);
  localparam logic TMO_EN = (MEM_TIMEOUT != 32'd0);

  logic [2:0]       state_r, state_nxt_s;
  logic [31:0]      pc_r;
  logic [1:0]       trap_cause_r, trap_cause_nxt_s;
  logic [CNT_W-1:0] tmo_cnt_r, tmo_cnt_nxt_s;
  logic             tmo_hit_s;

  assign tmo_hit_s = TMO_EN && (tmo_cnt_r == TMO_LAST);

  // Next-state, timeout counter and trap-cause selection
  always_comb begin
    state_nxt_s      = state_r;
    tmo_cnt_nxt_s    = tmo_cnt_r;
    trap_cause_nxt_s = trap_cause_r;
    case (state_r)
      S_FETCH: begin
        if (stall) begin
          state_nxt_s = S_FETCH;
        end else if (imem_ready) begin
          state_nxt_s = S_DECODE;
        end else if (tmo_hit_s) begin
          state_nxt_s      = S_TRAP;
          trap_cause_nxt_s = 2'b10;
        end else begin
          tmo_cnt_nxt_s = tmo_cnt_r + CNT_W'(1'b1);
        end
      end
      S_DECODE: begin
        if (illegal) begin
          state_nxt_s      = S_TRAP;
          trap_cause_nxt_s = 2'b01;
        end else begin
          state_nxt_s = S_EXEC;
        end
      end
      S_EXEC: begin
        if (is_load || is_store) begin
          state_nxt_s   = S_MEM;
          tmo_cnt_nxt_s = '0;
        end else begin
          state_nxt_s = S_WB;
        end
      end
      S_MEM: begin
        // ready in the limit cycle still completes the access
        if (dmem_ready) begin
          state_nxt_s = S_WB;
        end else if (tmo_hit_s) begin
          state_nxt_s      = S_TRAP;
          trap_cause_nxt_s = 2'b11;
        end else begin
          tmo_cnt_nxt_s = tmo_cnt_r + CNT_W'(1'b1);
        end
      end
      S_WB: begin
        state_nxt_s   = S_FETCH;
        tmo_cnt_nxt_s = '0;
      end
      S_TRAP: begin
        state_nxt_s = S_TRAP;
      end
      default: begin
        state_nxt_s   = S_FETCH;
        tmo_cnt_nxt_s = '0;
      end
    endcase
  end

  // State, PC and trap registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= S_FETCH;
      pc_r         <= RESET_PC;
      trap_cause_r <= 2'b00;
      tmo_cnt_r    <= '0;
    end else begin
      state_r      <= state_nxt_s;
      trap_cause_r <= trap_cause_nxt_s;
      tmo_cnt_r    <= tmo_cnt_nxt_s;
      if (state_r == S_WB) begin
        pc_r <= branch_taken ? branch_target : (pc_r + PC_STEP);
      end else begin
        pc_r <= pc_r;
      end
    end
  end

  // Strobes are decoded from state; the latch enable tracks the ready it qualifies
  assign imem_req      = (state_r == S_FETCH) && !stall;
  assign inst_latch_en = (state_r == S_FETCH) && !stall && imem_ready;
  assign alu_en        = (state_r == S_EXEC);
  assign dmem_req      = (state_r == S_MEM);
  assign dmem_we       = (state_r == S_MEM) && is_store;
  assign rf_we         = (state_r == S_WB) && writes_rd && !is_store;
  assign retire        = (state_r == S_WB);
  assign trap          = (state_r == S_TRAP);
  assign trap_cause    = trap_cause_r;
  assign pc            = pc_r;

`ifdef SEQ_INSTRET_EN
  logic [31:0] instret_r;

  // Retired-instruction counter, wraps naturally at 32 bits
  always_ff @(posedge clk) begin
    if (reset) begin
      instret_r <= 32'h0;
    end else if (state_r == S_WB) begin
      instret_r <= instret_r + 32'd1;
    end else begin
      instret_r <= instret_r;
    end
  end

  assign instret = instret_r;
`else
  assign instret = 32'h0;
`endif

endmodule

// File: tb/tb_stage_sequencer.sv
// Table-driven bench for stage_sequencer: per-cycle input/expected records fed through a scoreboard queue.
module tb_stage_sequencer;

  logic        clk = 1'b0;
  logic        reset, stall, imem_ready, illegal, is_load, is_store, writes_rd;
  logic        branch_taken, dmem_ready;
  logic [31:0] branch_target;
  logic        imem_req, inst_latch_en, alu_en, dmem_req, dmem_we, rf_we, retire, trap;
  logic [31:0] pc, instret;
  logic [1:0]  trap_cause;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  stage_sequencer #(.RESET_PC(32'h0), .PC_STEP(32'd1), .MEM_TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .stall(stall),
    .imem_req(imem_req), .imem_ready(imem_ready), .inst_latch_en(inst_latch_en),
    .illegal(illegal), .is_load(is_load), .is_store(is_store), .writes_rd(writes_rd),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .alu_en(alu_en), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
    .rf_we(rf_we), .retire(retire), .pc(pc), .trap(trap), .trap_cause(trap_cause),
    .instret(instret)
  );

  // inputs {reset, stall, imem_ready, illegal, is_load, is_store, writes_rd, branch_taken, dmem_ready}
  localparam logic [8:0] I0  = 9'b000000000;
  localparam logic [8:0] RST = 9'b100000000;
  localparam logic [8:0] STL = 9'b010000000;
  localparam logic [8:0] IRD = 9'b001000000;
  localparam logic [8:0] ILL = 9'b000100000;
  localparam logic [8:0] LD  = 9'b000010000;
  localparam logic [8:0] ST  = 9'b000001000;
  localparam logic [8:0] WRD = 9'b000000100;
  localparam logic [8:0] BR  = 9'b000000010;
  localparam logic [8:0] DRD = 9'b000000001;
  // strobes {imem_req, inst_latch_en, alu_en, dmem_req, dmem_we, rf_we, retire}
  localparam logic [6:0] S0  = 7'b0000000;
  localparam logic [6:0] REQ = 7'b1000000;
  localparam logic [6:0] LAT = 7'b0100000;
  localparam logic [6:0] ALU = 7'b0010000;
  localparam logic [6:0] DRQ = 7'b0001000;
  localparam logic [6:0] DWE = 7'b0000100;
  localparam logic [6:0] RFW = 7'b0000010;
  localparam logic [6:0] RET = 7'b0000001;

  typedef struct {
    string       name;
    logic [8:0]  in;
    logic [31:0] tgt;
    logic [6:0]  strb;
    logic [31:0] pc;
    logic        trp;
    logic [1:0]  cause;
    logic [31:0] ir;
  } vec_t;

  vec_t tab[$];
  vec_t sb_q[$];

  task automatic add(input string nm, input logic [8:0] in, input logic [31:0] tgt,
                     input logic [6:0] strb, input logic [31:0] p, input logic trp,
                     input logic [1:0] cause, input logic [31:0] ir);
    vec_t v;
    v.name = nm; v.in = in; v.tgt = tgt; v.strb = strb;
    v.pc = p; v.trp = trp; v.cause = cause; v.ir = ir;
    tab.push_back(v);
  endtask

  task automatic check(input string nm, input int row, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s row %0d: got %h expected %h", nm, row, act, exp);
    end
  endtask

  initial begin
    vec_t e;
    logic [31:0] exp_ir;
    // stall for 3 cycles, then 3 unanswered fetches, then an ADD completes on the 4th
    add("stall1", STL | IRD, 32'h0, S0, 32'h0, 1'b0, 2'b00, 32'd0);
    add("stall2", STL, 32'h0, S0, 32'h0, 1'b0, 2'b00, 32'd0);
    add("stall3", STL, 32'h0, S0, 32'h0, 1'b0, 2'b00, 32'd0);
    add("fw1", I0, 32'h0, REQ, 32'h0, 1'b0, 2'b00, 32'd0);
    add("fw2", I0, 32'h0, REQ, 32'h0, 1'b0, 2'b00, 32'd0);
    add("fw3", I0, 32'h0, REQ, 32'h0, 1'b0, 2'b00, 32'd0);
    add("add_f", IRD | WRD, 32'h0, REQ | LAT, 32'h0, 1'b0, 2'b00, 32'd0);
    add("add_d", WRD, 32'h0, S0, 32'h0, 1'b0, 2'b00, 32'd0);
    add("add_e", WRD, 32'h0, ALU, 32'h0, 1'b0, 2'b00, 32'd0);
    add("add_w", WRD, 32'h0, RFW | RET, 32'h0, 1'b0, 2'b00, 32'd0);
    // back-to-back 4-cycle ADD
    add("add2_f", IRD | WRD, 32'h0, REQ | LAT, 32'h1, 1'b0, 2'b00, 32'd1);
    add("add2_d", WRD, 32'h0, S0, 32'h1, 1'b0, 2'b00, 32'd1);
    add("add2_e", WRD, 32'h0, ALU, 32'h1, 1'b0, 2'b00, 32'd1);
    add("add2_w", WRD, 32'h0, RFW | RET, 32'h1, 1'b0, 2'b00, 32'd1);
    // load with dmem_ready on the 3rd MEM cycle
    add("ld_f", IRD | LD | WRD, 32'h0, REQ | LAT, 32'h2, 1'b0, 2'b00, 32'd2);
    add("ld_d", LD | WRD, 32'h0, S0, 32'h2, 1'b0, 2'b00, 32'd2);
    add("ld_e", LD | WRD, 32'h0, ALU, 32'h2, 1'b0, 2'b00, 32'd2);
    add("ld_m1", LD | WRD, 32'h0, DRQ, 32'h2, 1'b0, 2'b00, 32'd2);
    add("ld_m2", LD | WRD, 32'h0, DRQ, 32'h2, 1'b0, 2'b00, 32'd2);
    add("ld_m3", LD | WRD | DRD, 32'h0, DRQ, 32'h2, 1'b0, 2'b00, 32'd2);
    add("ld_w", LD | WRD, 32'h0, RFW | RET, 32'h2, 1'b0, 2'b00, 32'd2);
    // store: dmem_we high, rf_we suppressed despite writes_rd
    add("st_f", IRD | ST | WRD, 32'h0, REQ | LAT, 32'h3, 1'b0, 2'b00, 32'd3);
    add("st_d", ST | WRD, 32'h0, S0, 32'h3, 1'b0, 2'b00, 32'd3);
    add("st_e", ST | WRD, 32'h0, ALU, 32'h3, 1'b0, 2'b00, 32'd3);
    add("st_m", ST | WRD | DRD, 32'h0, DRQ | DWE, 32'h3, 1'b0, 2'b00, 32'd3);
    add("st_w", ST | WRD, 32'h0, RET, 32'h3, 1'b0, 2'b00, 32'd3);
    // taken branch to 0x20
    add("br_f", IRD | BR, 32'h20, REQ | LAT, 32'h4, 1'b0, 2'b00, 32'd4);
    add("br_d", BR, 32'h20, S0, 32'h4, 1'b0, 2'b00, 32'd4);
    add("br_e", BR, 32'h20, ALU, 32'h4, 1'b0, 2'b00, 32'd4);
    add("br_w", BR, 32'h20, RET, 32'h4, 1'b0, 2'b00, 32'd4);
    // load whose dmem_ready never comes: 4 MEM cycles then trap 11
    add("dt_f", IRD | LD, 32'h0, REQ | LAT, 32'h20, 1'b0, 2'b00, 32'd5);
    add("dt_d", LD, 32'h0, S0, 32'h20, 1'b0, 2'b00, 32'd5);
    add("dt_e", LD, 32'h0, ALU, 32'h20, 1'b0, 2'b00, 32'd5);
    add("dt_m1", LD, 32'h0, DRQ, 32'h20, 1'b0, 2'b00, 32'd5);
    add("dt_m2", LD, 32'h0, DRQ, 32'h20, 1'b0, 2'b00, 32'd5);
    add("dt_m3", LD, 32'h0, DRQ, 32'h20, 1'b0, 2'b00, 32'd5);
    add("dt_m4", LD, 32'h0, DRQ, 32'h20, 1'b0, 2'b00, 32'd5);
    add("dt_trap", LD, 32'h0, S0, 32'h20, 1'b1, 2'b11, 32'd5);
    add("dt_hold", IRD | DRD | LD, 32'h0, S0, 32'h20, 1'b1, 2'b11, 32'd5);
    add("rst1", RST, 32'h0, S0, 32'h20, 1'b1, 2'b11, 32'd5);
    // imem timeout: exactly 4 request cycles then trap 10
    add("it_w1", I0, 32'h0, REQ, 32'h0, 1'b0, 2'b00, 32'd0);
    add("it_w2", I0, 32'h0, REQ, 32'h0, 1'b0, 2'b00, 32'd0);
    add("it_w3", I0, 32'h0, REQ, 32'h0, 1'b0, 2'b00, 32'd0);
    add("it_w4", I0, 32'h0, REQ, 32'h0, 1'b0, 2'b00, 32'd0);
    add("it_trap", IRD, 32'h0, S0, 32'h0, 1'b1, 2'b10, 32'd0);
    add("rst2", RST, 32'h0, S0, 32'h0, 1'b1, 2'b10, 32'd0);
    // illegal instruction
    add("il_f", IRD | ILL | WRD, 32'h0, REQ | LAT, 32'h0, 1'b0, 2'b00, 32'd0);
    add("il_d", ILL | WRD, 32'h0, S0, 32'h0, 1'b0, 2'b00, 32'd0);
    add("il_trap", ILL | WRD, 32'h0, S0, 32'h0, 1'b1, 2'b01, 32'd0);
    add("rst3", RST, 32'h0, S0, 32'h0, 1'b1, 2'b01, 32'd0);
    // reset during a MEM wait drops the request
    add("mr_f", IRD | ST, 32'h0, REQ | LAT, 32'h0, 1'b0, 2'b00, 32'd0);
    add("mr_d", ST, 32'h0, S0, 32'h0, 1'b0, 2'b00, 32'd0);
    add("mr_e", ST, 32'h0, ALU, 32'h0, 1'b0, 2'b00, 32'd0);
    add("mr_m", ST, 32'h0, DRQ | DWE, 32'h0, 1'b0, 2'b00, 32'd0);
    add("mr_rst", RST | ST, 32'h0, DRQ | DWE, 32'h0, 1'b0, 2'b00, 32'd0);
    // after reset: imem_ready in the 4th request cycle beats the timeout
    add("lim_w1", I0, 32'h0, REQ, 32'h0, 1'b0, 2'b00, 32'd0);
    add("lim_w2", I0, 32'h0, REQ, 32'h0, 1'b0, 2'b00, 32'd0);
    add("lim_w3", I0, 32'h0, REQ, 32'h0, 1'b0, 2'b00, 32'd0);
    add("lim_f", IRD | WRD, 32'h0, REQ | LAT, 32'h0, 1'b0, 2'b00, 32'd0);
    add("lim_d", WRD, 32'h0, S0, 32'h0, 1'b0, 2'b00, 32'd0);
    add("lim_e", WRD, 32'h0, ALU, 32'h0, 1'b0, 2'b00, 32'd0);
    add("lim_w", WRD, 32'h0, RFW | RET, 32'h0, 1'b0, 2'b00, 32'd0);
    add("final", STL, 32'h0, S0, 32'h1, 1'b0, 2'b00, 32'd1);

    reset = 1'b1; stall = 1'b0; imem_ready = 1'b0; illegal = 1'b0; is_load = 1'b0;
    is_store = 1'b0; writes_rd = 1'b0; branch_taken = 1'b0; dmem_ready = 1'b0;
    branch_target = 32'h0;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < tab.size(); i++) begin
      {reset, stall, imem_ready, illegal, is_load, is_store, writes_rd, branch_taken, dmem_ready} = tab[i].in;
      branch_target = tab[i].tgt;
      sb_q.push_back(tab[i]);
      @(negedge clk);
      e = sb_q.pop_front();
`ifdef SEQ_INSTRET_EN
      exp_ir = e.ir;
`else
      exp_ir = 32'h0;
`endif
      check({e.name, ".strobes"}, i,
            {25'h0, imem_req, inst_latch_en, alu_en, dmem_req, dmem_we, rf_we, retire},
            {25'h0, e.strb});
      check({e.name, ".pc"}, i, pc, e.pc);
      check({e.name, ".trap"}, i, {31'h0, trap}, {31'h0, e.trp});
      check({e.name, ".cause"}, i, {30'h0, trap_cause}, {30'h0, e.cause});
      check({e.name, ".instret"}, i, instret, exp_ir);
      @(posedge clk);
      #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
